// File: rtl/arm_mem_pkg.sv
// Shared definitions for the memory-stage SRAM controller and its bench:
// FSM state encoding and the default byte address of SRAM word 0.
package arm_mem_pkg;

  localparam int unsigned ADDR_BASE_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_access_timer.sv
// Per-phase cycle counter: cleared by start on every phase entry, flags
// phase_done in the last cycle of an ACCESS_CYCLES-long phase.
module mem_access_timer #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic phase_done
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_done = active && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (active && !phase_done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: each 32-bit load/store becomes two 16-bit SRAM
// accesses (low half, then high half); ready low freezes the pipeline.
module mem_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_BASE     = ADDR_BASE_DEFAULT,
  parameter int          SRAM_AW       = 18,
  parameter int          ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        ST_val,
  output logic               ready,
  output logic [31:0]        MEM_read_value,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N
);

  localparam int WW = SRAM_AW - 1;

  mem_state_e    state_q, state_d;
  logic          write_q, write_d;
  logic [WW-1:0] word_q, word_d;
  logic [31:0]   st_q, st_d;
  logic [15:0]   lo_q, lo_d;
  logic [31:0]   rdval_q, rdval_d;

  logic        req;
  logic        accept;
  logic        phase_start;
  logic        phase_active;
  logic        phase_done;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign req          = MEM_R_EN | MEM_W_EN;
  assign accept       = (state_q == IDLE) && req;
  assign phase_active = (state_q == LO) || (state_q == HI);
  assign phase_start  = accept || ((state_q == LO) && phase_done);

  mem_access_timer #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (phase_start),
    .active     (phase_active),
    .phase_done (phase_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE never accepts a request: the pipeline has not advanced yet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = LO;
      LO:      if (phase_done) state_d = HI;
      HI:      if (phase_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_d = write_q;
    word_d  = word_q;
    st_d    = st_q;
    lo_d    = lo_q;
    rdval_d = rdval_q;
    if (accept) begin
      write_d = MEM_W_EN;
      word_d  = WW'((ALU_result - 32'(ADDR_BASE)) >> 2);
      st_d    = ST_val;
    end
    if ((state_q == LO) && phase_done && !write_q) begin
      lo_d = SRAM_DQ;
    end
    if ((state_q == HI) && phase_done && !write_q) begin
      rdval_d = {SRAM_DQ, lo_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      word_q  <= '0;
      st_q    <= '0;
      lo_q    <= '0;
      rdval_q <= '0;
    end else begin
      write_q <= write_d;
      word_q  <= word_d;
      st_q    <= st_d;
      lo_q    <= lo_d;
      rdval_q <= rdval_d;
    end
  end

  // Bus controls decode from state only, so reset releases the bus at once.
  always_comb begin
    ready     = (state_q == DONE) || ((state_q == IDLE) && !req);
    dq_oe     = write_q && phase_active;
    SRAM_WE_N = !dq_oe;
    dq_out    = (state_q == HI) ? st_q[31:16] : st_q[15:0];
    SRAM_ADDR = {word_q, (state_q == HI)};
  end

  assign SRAM_DQ        = dq_oe ? dq_out : 16'bz;
  assign MEM_read_value = rdval_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: three instances (A=2, 1, 3) each with
// its own behavioural SRAM; only the instance under test is out of reset.
module tb_mem_sram_ctrl;
  import arm_mem_pkg::*;

  logic        clk;
  logic        rstN2, rstN1, rstN3;
  logic        rdEn, wrEn;
  logic [31:0] aluRes, stVal;

  logic        ready2, ready1, ready3;
  logic [31:0] rv2, rv1, rv3;
  logic [17:0] addr2, addr1, addr3;
  logic        we2, we1, we3;
  wire  [15:0] dq2, dq1, dq3;

  logic        drv2, drv1, drv3;
  logic        memClear;
  logic [15:0] mem2 [0:255];
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];

  int vectors;
  int miscompares;

  mem_sram_ctrl #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rstN2), .MEM_R_EN(rdEn), .MEM_W_EN(wrEn),
    .ALU_result(aluRes), .ST_val(stVal), .ready(ready2),
    .MEM_read_value(rv2), .SRAM_ADDR(addr2), .SRAM_DQ(dq2), .SRAM_WE_N(we2)
  );

  mem_sram_ctrl #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rstN1), .MEM_R_EN(rdEn), .MEM_W_EN(wrEn),
    .ALU_result(aluRes), .ST_val(stVal), .ready(ready1),
    .MEM_read_value(rv1), .SRAM_ADDR(addr1), .SRAM_DQ(dq1), .SRAM_WE_N(we1)
  );

  mem_sram_ctrl #(.ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .rst(rstN3), .MEM_R_EN(rdEn), .MEM_W_EN(wrEn),
    .ALU_result(aluRes), .ST_val(stVal), .ready(ready3),
    .MEM_read_value(rv3), .SRAM_ADDR(addr3), .SRAM_DQ(dq3), .SRAM_WE_N(we3)
  );

  // SRAM models drive the bus only when the bench asks them to.
  assign dq2 = drv2 ? mem2[addr2[7:0]] : 16'bz;
  assign dq1 = drv1 ? mem1[addr1[7:0]] : 16'bz;
  assign dq3 = drv3 ? mem3[addr3[7:0]] : 16'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories are preset to 0x1000+index, then capture writes on clock edges.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) begin
        mem2[i] <= 16'h1000 + 16'(i);
        mem1[i] <= 16'h1000 + 16'(i);
        mem3[i] <= 16'h1000 + 16'(i);
      end
    end else begin
      if (!we2) mem2[addr2[7:0]] <= dq2;
      if (!we1) mem1[addr1[7:0]] <= dq1;
      if (!we3) mem3[addr3[7:0]] <= dq3;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic getReady(input int a);
    case (a)
      1:       return ready1;
      3:       return ready3;
      default: return ready2;
    endcase
  endfunction

  function automatic logic getWe(input int a);
    case (a)
      1:       return we1;
      3:       return we3;
      default: return we2;
    endcase
  endfunction

  function automatic logic [17:0] getAddr(input int a);
    case (a)
      1:       return addr1;
      3:       return addr3;
      default: return addr2;
    endcase
  endfunction

  function automatic logic [15:0] getDq(input int a);
    case (a)
      1:       return dq1;
      3:       return dq3;
      default: return dq2;
    endcase
  endfunction

  function automatic logic [31:0] getRv(input int a);
    case (a)
      1:       return rv1;
      3:       return rv3;
      default: return rv2;
    endcase
  endfunction

  task automatic setDrive(input int a, input logic v);
    case (a)
      1:       drv1 = v;
      3:       drv3 = v;
      default: drv2 = v;
    endcase
  endtask

  // Called just after a rising edge; runs one full access on instance a and
  // returns just after the edge that enters the following IDLE cycle.
  task automatic applyStimulus(input int a, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] val,
                               input bit garbage, input logic [31:0] expRv);
    logic [16:0] word;
    logic        hi;
    int          lowCycles;
    bit          done;
    word = 17'((addr - 32'(ADDR_BASE_DEFAULT)) >> 2);
    rdEn = rd;
    wrEn = wr;
    aluRes = addr;
    stVal = val;
    setDrive(a, rd && !wr);
    lowCycles = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (getReady(a)) begin
        done = 1'b1;
      end else begin
        if (lowCycles >= 1) begin
          hi = (lowCycles > a);
          checkOutput("sram_addr", 32'(getAddr(a)), 32'({word, hi}));
          checkOutput("sram_we_n", 32'(getWe(a)), wr ? 32'd0 : 32'd1);
          if (wr) checkOutput("sram_dq", 32'(getDq(a)), hi ? 32'(val[31:16]) : 32'(val[15:0]));
        end
        lowCycles++;
        @(posedge clk);
        #1;
        if (garbage && lowCycles == 1) begin
          aluRes = 32'hFFFF_FFF0;
          stVal  = 32'h0BAD_0BAD;
          wrEn   = 1'b1;
        end
      end
    end
    checkOutput("ready_low_cycles", 32'(lowCycles), 32'(2 * a + 1));
    checkOutput("read_value_done", getRv(a), expRv);
    @(posedge clk);
    #1;
    rdEn = 1'b0;
    wrEn = 1'b0;
    setDrive(a, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstN2 = 1'b0;
    rstN1 = 1'b0;
    rstN3 = 1'b0;
    rdEn = 1'b0;
    wrEn = 1'b0;
    aluRes = '0;
    stVal = '0;
    drv2 = 1'b0;
    drv1 = 1'b0;
    drv3 = 1'b0;
    memClear = 1'b1;

    #1;
    checkOutput("reset_ready", 32'(ready2), 32'd1);
    checkOutput("reset_we_n", 32'(we2), 32'd1);
    checkOutput("reset_read_value", rv2, 32'd0);
    checkOutput("reset_addr", 32'(addr2), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    memClear = 1'b0;
    rstN2 = 1'b1;

    // Quiet bus: model drives word 0, so the bus shows its contents.
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_ready", 32'(ready2), 32'd1);
    checkOutput("idle_we_n", 32'(we2), 32'd1);
    checkOutput("idle_read_value", rv2, 32'd0);
    drv2 = 1'b1;
    #1;
    checkOutput("idle_dq_released", 32'(dq2), 32'h1000);
    drv2 = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(2, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 1'b0, 32'd0);
    checkOutput("store_mem4", 32'(mem2[4]), 32'h0000_BEEF);
    checkOutput("store_mem5", 32'(mem2[5]), 32'h0000_DEAD);

    applyStimulus(2, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, 32'hDEAD_BEEF);

    applyStimulus(2, 1'b0, 1'b1, 32'd1036, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(2, 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, 32'h1234_5678);
    checkOutput("b2b_mem6", 32'(mem2[6]), 32'h0000_5678);
    checkOutput("b2b_mem7", 32'(mem2[7]), 32'h0000_1234);

    applyStimulus(2, 1'b1, 1'b1, 32'd1024, 32'h0000_A5A5, 1'b0, 32'h1234_5678);
    checkOutput("both_mem0", 32'(mem2[0]), 32'h0000_A5A5);
    checkOutput("both_mem1", 32'(mem2[1]), 32'h0000_0000);

    // Abort a store in its HI phase with an asynchronous reset pulse.
    wrEn = 1'b1;
    aluRes = 32'd1044;
    stVal = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_pre_we_n", 32'(we2), 32'd0);
    checkOutput("abort_pre_addr", 32'(addr2), 32'd11);
    rstN2 = 1'b0;
    wrEn = 1'b0;
    drv2 = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(ready2), 32'd1);
    checkOutput("abort_we_n", 32'(we2), 32'd1);
    checkOutput("abort_addr", 32'(addr2), 32'd0);
    checkOutput("abort_read_value", rv2, 32'd0);
    checkOutput("abort_dq_released", 32'(dq2), 32'h0000_A5A5);
    @(posedge clk);
    #1;
    drv2 = 1'b0;
    rstN2 = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(2, 1'b0, 1'b1, 32'd1040, 32'h0F1E_2D3C, 1'b0, 32'd0);
    applyStimulus(2, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 32'h0F1E_2D3C);
    rstN2 = 1'b0;

    rstN1 = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 1'b1, 32'd1040, 32'h89AB_CDEF, 1'b0, 32'd0);
    checkOutput("a1_mem8", 32'(mem1[8]), 32'h0000_CDEF);
    checkOutput("a1_mem9", 32'(mem1[9]), 32'h0000_89AB);
    applyStimulus(1, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 32'h89AB_CDEF);
    rstN1 = 1'b0;

    rstN3 = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(3, 1'b0, 1'b1, 32'd1040, 32'h7654_3210, 1'b0, 32'd0);
    checkOutput("a3_mem8", 32'(mem3[8]), 32'h0000_3210);
    checkOutput("a3_mem9", 32'(mem3[9]), 32'h0000_7654);
    applyStimulus(3, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 32'h7654_3210);
    rstN3 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
